// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Signs are applied in a final fix-up cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | one radix-2 step per cycle while the step counter is below 32;
//       | the cycle where the counter reads 32 hands off to FIX
// FIX   | sign correction; HI/LO written at this state's edge
// DONE  | one-cycle done pulse; MTHI/MTLO writes accepted, start ignored
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            op_div,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            write_hi,
    input  logic            write_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] STEPS = 6'(XLEN);

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    // acc_hi holds the running partial product / remainder,
    // acc_lo the multiplier being consumed / quotient being built.
    logic [XLEN-1:0] acc_hi_q, acc_hi_d;
    logic [XLEN-1:0] acc_lo_q, acc_lo_d;
    logic [XLEN-1:0] mag2_q, mag2_d;
    logic            div_q, div_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            dbz_q, dbz_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] product_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              op2_zero;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath and result registers; reset drops any in-flight work
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            mag2_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            mag2_q    <= mag2_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state, iteration step and result/write selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        mag2_d    = mag2_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        mag1     = (!is_unsigned && op1[XLEN-1]) ? -op1 : op1;
        mag2     = (!is_unsigned && op2[XLEN-1]) ? -op2 : op2;
        op2_zero = (op2 == '0);

        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag2_q} : '0);
        // Remainder is always below the divisor, so the shifted value fits
        // in XLEN+1 bits and the MSB of the difference is a valid borrow.
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag2_q};

        product     = {acc_hi_q, acc_lo_q};
        product_fix = neg_res_q ? -product : product;
        quot_fix    = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_fix     = neg_rem_q ? -acc_hi_q : acc_hi_q;

        case (state_q)
            IDLE: begin
                if (write_hi) hi_d = wdata;
                if (write_lo) lo_d = wdata;
                if (start) begin
                    div_d     = op_div;
                    neg_res_d = !is_unsigned && (op1[XLEN-1] ^ op2[XLEN-1]);
                    neg_rem_d = !is_unsigned && op1[XLEN-1];
                    dbz_d     = op_div && op2_zero;
                    cnt_d     = '0;
                    if (op_div && op2_zero) begin
                        state_d = DONE;
                    end else begin
                        acc_hi_d = '0;
                        acc_lo_d = mag1;
                        mag2_d   = mag2;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == STEPS) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (div_q) begin
                        if (!div_diff[XLEN]) begin
                            acc_hi_d = div_diff[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi_d = div_shift[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum[XLEN:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                end
            end
            FIX: begin
                if (div_q) begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = product_fix[2*XLEN-1:XLEN];
                    lo_d = product_fix[XLEN-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (write_hi) hi_d = wdata;
                if (write_lo) lo_d = wdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign div_by_zero = (state_q == DONE) && dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
